// File: rtl/poly_op_ctrl.sv
// ----------------------------------------------------------------------------
// poly_op_ctrl
//
// Operation sequencer that sits in front of addr_gen in the Kyber polynomial
// datapath. A start strobe in IDLE latches the operation mode. The block then
// runs a cycle counter over the operation length, issues coefficient-RAM reads
// for every counter value, and replays those reads as writes PIPE_LAT cycles
// later, once they have passed through the butterfly pipeline. It raises busy
// for the whole operation and pulses done once the last write has been issued.
//
// Optional feature (macro POLY_OP_STALL_EN):
//   Adds a 'stall' input. While stall is high in RUN or DRAIN, the sequence
//   freezes in place and both memory enables are suppressed.
//
// Ports:
//   clk          in   system clock (rising edge)
//   rst          in   synchronous reset, active-high
//   start        in   command strobe, only sampled in IDLE
//   mode_in      in   [1:0] 0:NTT 1:INVNTT 2:MULT 3:ADDSUB
//   stall        in   sequence hold (only with POLY_OP_STALL_EN)
//   mode         out  [1:0] latched operation mode
//   clk_counter  out  [7:0] running cycle index
//   stage        out  [2:0] clk_counter[7:5], current NTT layer
//   rd_en        out  coefficient RAM read enable
//   wr_en        out  coefficient RAM write enable (rd_en delayed PIPE_LAT)
//   busy         out  high from accepted start until last write
//   done         out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module poly_op_ctrl #(
    parameter int NTT_CYCLES    = 224,
    parameter int INVNTT_CYCLES = 224,
    parameter int MULT_CYCLES   = 64,
    parameter int ADDSUB_CYCLES = 32,
    parameter int PIPE_LAT      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode_in,
`ifdef POLY_OP_STALL_EN
    input  logic       stall,
`endif
    output logic [1:0] mode,
    output logic [7:0] clk_counter,
    output logic [2:0] stage,
    output logic       rd_en,
    output logic       wr_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Final counter value for a given operation mode.
    function automatic logic [7:0] last_index(input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = 8'(NTT_CYCLES - 1);
            2'd1:    r = 8'(INVNTT_CYCLES - 1);
            2'd2:    r = 8'(MULT_CYCLES - 1);
            2'd3:    r = 8'(ADDSUB_CYCLES - 1);
            default: r = 8'(NTT_CYCLES - 1);
        endcase
        return r;
    endfunction

    localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

    state_t                state_r, state_s;
    logic [1:0]            mode_r, mode_s;
    logic [7:0]            cnt_r, cnt_s;
    logic                  rd_r, rd_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic [3:0]            drain_r, drain_s;
    logic [PIPE_LAT-1:0]   sr_r, sr_s;
    logic [PIPE_LAT:0]     shift_ext_s;
    logic [7:0]            last_s;
    logic                  stall_eff_s;

    // Stall only freezes an operation in flight; IDLE and DONE ignore it.
`ifdef POLY_OP_STALL_EN
    assign stall_eff_s = stall & ((state_r == RUN) | (state_r == DRAIN));
`else
    assign stall_eff_s = 1'b0;
`endif

    // Read-enable history; bit PIPE_LAT-1 is the read issued PIPE_LAT cycles ago.
    assign shift_ext_s = {sr_r, rd_r};
    assign last_s      = last_index(mode_r);

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        cnt_s   = cnt_r;
        rd_s    = rd_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        drain_s = drain_r;
        if (stall_eff_s) begin
            sr_s = sr_r;
        end else begin
            sr_s = shift_ext_s[PIPE_LAT-1:0];
        end

        case (state_r)
            IDLE: begin
                cnt_s   = 8'd0;
                rd_s    = 1'b0;
                busy_s  = 1'b0;
                drain_s = 4'd0;
                if (start) begin
                    mode_s  = mode_in;
                    state_s = RUN;
                    busy_s  = 1'b1;
                    rd_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (stall_eff_s) begin
                    state_s = RUN;
                end else if (cnt_r == last_s) begin
                    state_s = DRAIN;
                    rd_s    = 1'b0;
                    cnt_s   = 8'd0;
                    drain_s = 4'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            DRAIN: begin
                // The last read needs PIPE_LAT cycles to emerge as a write.
                if (stall_eff_s) begin
                    state_s = DRAIN;
                end else if (drain_r == DRAIN_LAST) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    drain_s = drain_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
                rd_s    = 1'b0;
                busy_s  = 1'b0;
                drain_s = 4'd0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            mode_r  <= 2'd0;
            cnt_r   <= 8'd0;
            rd_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            drain_r <= 4'd0;
            sr_r    <= '0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            cnt_r   <= cnt_s;
            rd_r    <= rd_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            drain_r <= drain_s;
            sr_r    <= sr_s;
        end
    end

    assign mode        = mode_r;
    assign clk_counter = cnt_r;
    assign stage       = cnt_r[7:5];
    assign rd_en       = rd_r & ~stall_eff_s;
    assign wr_en       = sr_r[PIPE_LAT-1] & ~stall_eff_s;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_poly_op_ctrl.sv
// ----------------------------------------------------------------------------
// tb_poly_op_ctrl
//
// Scoreboard bench for poly_op_ctrl. Each accepted start pushes the expected
// mode and length; a negedge monitor pops the entry when busy rises and checks
// every cycle of the operation against the timing implied by that length.
// ----------------------------------------------------------------------------
module tb_poly_op_ctrl;

    localparam int P = 4;

    typedef struct {
        logic [1:0] mode;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode_in = 2'd0;
    logic       stall_drv = 1'b0;
    logic [1:0] mode;
    logic [7:0] clk_counter;
    logic [2:0] stage;
    logic       rd_en, wr_en, busy, done;

    exp_t sb[$];
    exp_t cur;
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   rel = 0;
    int   stalls = 0;
    int   op_start = 0;
    int   last_done = 0;
    int   last_done_lat = 0;
    int   ops_done = 0;
    bit   in_op = 1'b0;
    bit   zero_next = 1'b0;
    bit   b2b = 1'b0;
    logic [7:0] exp_cnt;

    poly_op_ctrl #(
        .NTT_CYCLES(224), .INVNTT_CYCLES(224), .MULT_CYCLES(64),
        .ADDSUB_CYCLES(32), .PIPE_LAT(P)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
`ifdef POLY_OP_STALL_EN
        .stall(stall_drv),
`endif
        .mode(mode), .clk_counter(clk_counter), .stage(stage),
        .rd_en(rd_en), .wr_en(wr_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int len_of(input logic [1:0] m);
        case (m)
            2'd0:    return 224;
            2'd1:    return 224;
            2'd2:    return 64;
            default: return 32;
        endcase
    endfunction

    // Monitor: pops the expected operation when busy rises, checks each cycle.
    always @(negedge clk) begin
        if (zero_next) begin
            check_eq("rst_outputs_zero",
                     {mode, clk_counter, stage, rd_en, wr_en, busy, done}, 32'd0);
            zero_next = 1'b0;
        end
        if (!in_op && busy === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_start", 32'd1, 32'd0);
            end else begin
                cur      = sb.pop_front();
                in_op    = 1'b1;
                rel      = 0;
                stalls   = 0;
                op_start = cyc;
                if (b2b) check_eq("b2b_gap", cyc - last_done, 32'd2);
            end
        end
        if (in_op) begin
            exp_cnt = (rel < cur.len) ? 8'(rel) : 8'd0;
            if (stall_drv) begin
                stalls++;
                check_eq("stall_cnt_hold", clk_counter, exp_cnt);
                check_eq("stall_rd_wr", {rd_en, wr_en}, 32'd0);
                check_eq("stall_busy", busy, 32'd1);
            end else begin
                check_eq("clk_counter", clk_counter, exp_cnt);
                check_eq("stage", stage, exp_cnt[7:5]);
                check_eq("rd_en", rd_en, rel < cur.len);
                check_eq("wr_en", wr_en, (rel >= P) && (rel < cur.len + P));
                check_eq("busy", busy, rel < cur.len + P);
                check_eq("done", done, rel == cur.len + P);
                check_eq("mode", mode, cur.mode);
                if (rel == cur.len + P) begin
                    check_eq("done_latency", cyc - op_start, cur.len + P + stalls);
                    last_done     = cyc;
                    last_done_lat = cyc - op_start;
                    ops_done++;
                    in_op = 1'b0;
                end
                rel++;
            end
        end else begin
            check_eq("done_when_idle", done, 32'd0);
        end
        if (rst) begin
            in_op     = 1'b0;
            zero_next = 1'b1;
        end
    end

    // Launch one operation; the expectation goes into the scoreboard.
    // Returns two time units into relative cycle 0.
    task automatic start_op(input logic [1:0] m);
        exp_t e;
        @(posedge clk); #2;
        start   = 1'b1;
        mode_in = m;
        e.mode  = m;
        e.len   = len_of(m);
        sb.push_back(e);
        @(posedge clk); #2;
        start   = 1'b0;
        mode_in = ~m;
    endtask

    task automatic wait_ops(input int target);
        int budget = 0;
        while (ops_done < target && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        check_eq("op_complete", ops_done >= target, 32'd1);
    endtask

    initial begin
        exp_t e;
        int base;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_state", {mode, clk_counter, stage, rd_en, wr_en, busy, done}, 32'd0);

        // NTT full run
        start_op(2'd0);
        wait_ops(1);
        check_eq("ntt_done_cycle", last_done_lat, 32'd228);

        // ADDSUB
        start_op(2'd3);
        wait_ops(2);
        check_eq("addsub_done_cycle", last_done_lat, 32'd36);

        // MULT with an ignored second start at cycle 10
        start_op(2'd2);
        repeat (9) @(posedge clk);
        #2;
        start   = 1'b1;
        mode_in = 2'd1;
        @(posedge clk); #2;
        start   = 1'b0;
        wait_ops(3);
        check_eq("mult_done_cycle", last_done_lat, 32'd68);

        // NTT aborted by reset at cycle 100, then a fresh full NTT
        start_op(2'd0);
        repeat (99) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        repeat (300) @(posedge clk);
        check_eq("no_done_after_abort", ops_done, 32'd3);
        start_op(2'd0);
        wait_ops(4);
        check_eq("ntt_after_rst_cycle", last_done_lat, 32'd228);

        // start held high: back-to-back INVNTT operations
        base = ops_done;
        e.mode = 2'd1;
        e.len  = 224;
        repeat (3) sb.push_back(e);
        @(posedge clk); #2;
        start   = 1'b1;
        mode_in = 2'd1;
        wait_ops(base + 1);
        b2b = 1'b1;
        wait_ops(base + 2);
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
        wait_ops(base + 3);
        b2b = 1'b0;

`ifdef POLY_OP_STALL_EN
        // ADDSUB stalled during cycles 10..14
        base = ops_done;
        start_op(2'd3);
        repeat (9) @(posedge clk);
        #2 stall_drv = 1'b1;
        repeat (5) @(posedge clk);
        #2 stall_drv = 1'b0;
        wait_ops(base + 1);
        check_eq("stall_done_cycle", last_done_lat, 32'd41);
`endif

        repeat (5) @(posedge clk);
        check_eq("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
